// File: rtl/norm_phase_seq.sv
// Normal-mode sequencer: rotates the green grant across four approaches with an
// all-red clearance after each green, parking on norm_op_en low and resuming the same approach.
module norm_phase_seq #(
    parameter int unsigned GREEN_CYCLES = 20,
    parameter int unsigned CLEAR_CYCLES = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       norm_op_en,
    input  logic       norm_counter_en,
    output logic       allow_0_norm,
    output logic       allow_1_norm,
    output logic       allow_2_norm,
    output logic       allow_3_norm,
    output logic [1:0] phase,
    output logic       phase_done
);

    localparam int unsigned NUM_APPROACH = 4;
    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GREEN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [1:0]                phase_q, phase_d;
    logic [NUM_APPROACH-1:0]   allow_q, allow_d;
    logic                      done_c;

    // State, counter, phase and registered grant vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= 2'd0;
            allow_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            allow_q <= allow_d;
        end
    end

    // Next-state logic; losing norm_op_en parks in IDLE with the phase kept for resumption
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        done_c  = 1'b0;

        if (!norm_op_en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = GREEN;
                    cnt_d   = '0;
                end
                GREEN: begin
                    if (norm_counter_en) begin
                        if (cnt_q == GREEN_LAST) begin
                            state_d = CLEAR;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                CLEAR: begin
                    if (norm_counter_en) begin
                        if (cnt_q == CLEAR_LAST) begin
                            done_c  = 1'b1;
                            state_d = GREEN;
                            cnt_d   = '0;
                            phase_d = phase_q + 2'd1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        allow_d = (state_d == GREEN) ? (NUM_APPROACH'(1) << phase_d) : '0;
    end

    assign allow_0_norm = allow_q[0];
    assign allow_1_norm = allow_q[1];
    assign allow_2_norm = allow_q[2];
    assign allow_3_norm = allow_q[3];
    assign phase        = phase_q;
    assign phase_done   = done_c;

endmodule

// File: tb/tb_norm_phase_seq.sv
// Bench for norm_phase_seq: directed scenarios plus random enables, checked against a
// remaining-time interval model of the signal rotation.
module tb_norm_phase_seq;

    localparam int unsigned G = 5;
    localparam int unsigned C = 2;

    logic clk = 1'b0;
    logic rst_n, op_en, cnt_en;
    logic allow_0, allow_1, allow_2, allow_3, phase_done;
    logic [1:0] phase;
    logic [3:0] allow;

    int vectors = 0;
    int errors  = 0;

    norm_phase_seq #(.GREEN_CYCLES(G), .CLEAR_CYCLES(C), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .norm_op_en(op_en), .norm_counter_en(cnt_en),
        .allow_0_norm(allow_0), .allow_1_norm(allow_1),
        .allow_2_norm(allow_2), .allow_3_norm(allow_3),
        .phase(phase), .phase_done(phase_done)
    );

    always #5 clk = ~clk;
    assign allow = {allow_3, allow_2, allow_1, allow_0};

    // Model: which interval we are in and how many counted cycles remain in it
    bit m_on, m_green;
    int m_left, m_phase;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_on = 0; m_green = 0; m_left = 0; m_phase = 0;
        end else if (!op_en) begin
            m_on = 0;
        end else if (!m_on) begin
            m_on = 1; m_green = 1; m_left = G;
        end else if (cnt_en) begin
            m_left--;
            if (m_left == 0) begin
                if (m_green) begin
                    m_green = 0; m_left = C;
                end else begin
                    m_green = 1; m_left = G; m_phase = (m_phase + 1) % 4;
                end
            end
        end
    end

    function automatic logic [3:0] exp_allow();
        logic [3:0] one;
        one = 4'b0001;
        if (m_on && m_green) return one << m_phase;
        return 4'b0000;
    endfunction

    function automatic logic exp_done();
        return m_on && !m_green && cnt_en && op_en && (m_left == 1);
    endfunction

    task automatic drive(input logic op, input logic ce);
        op_en = op; cnt_en = ce;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; op_en = 1'b0; cnt_en = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance with both enables high until the model reaches the requested point
    task automatic run_to(input int ph, input bit green, input int left);
        int budget;
        budget = 200;
        while (!(m_on && m_phase == ph && m_green == green && m_left == left) && budget > 0) begin
            drive(1, 1);
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            vectors++; errors++;
            $display("FAIL run_to: target phase %0d green %0b left %0d never reached", ph, green, left);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom));
            vectors++;
            if (allow !== 4'b0 || phase !== 2'd0 || phase_done !== 1'b0) begin
                errors++;
                $display("FAIL reset: allow=%b phase=%0d done=%b, want 0000/0/0", allow, phase, phase_done);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_startup();
        logic [3:0] want;
        bit has_want;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            drive(1, 1);
            vectors++;
            if (allow !== exp_allow() || phase !== 2'(m_phase) || phase_done !== exp_done()) begin
                errors++;
                $display("FAIL startup c%0d: allow=%b phase=%0d done=%b, want %b/%0d/%b",
                         c, allow, phase, phase_done, exp_allow(), m_phase, exp_done());
            end
            has_want = 1; want = 4'b0000;
            if ((c >= 1 && c <= 5) || c == 29) want = 4'b0001;
            else if (c >= 8 && c <= 12)        want = 4'b0010;
            else if (!(c == 0 || c == 6 || c == 7)) has_want = 0;
            if (has_want) begin
                vectors++;
                if (allow !== want) begin
                    errors++;
                    $display("FAIL startup_abs c%0d: allow=%b, want %b", c, allow, want);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_freeze();
        int green_cnt;
        green_cnt = 0;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            drive(1, !(c >= 3 && c <= 5));
            vectors++;
            if (allow !== exp_allow() || phase !== 2'(m_phase) || phase_done !== exp_done()) begin
                errors++;
                $display("FAIL freeze c%0d: allow=%b phase=%0d done=%b, want %b/%0d/%b",
                         c, allow, phase, phase_done, exp_allow(), m_phase, exp_done());
            end
            if (allow_0) green_cnt++;
            @(negedge clk);
        end
        vectors++;
        if (green_cnt != 8) begin
            errors++;
            $display("FAIL freeze_len: allow_0 high %0d cycles, want 8", green_cnt);
        end
    endtask

    task automatic test_interrupt_green();
        logic [3:0] want;
        do_reset();
        run_to(2, 1, G - 3);
        drive(0, 1);
        vectors++;
        if (allow !== 4'b0100) begin
            errors++;
            $display("FAIL int_green_pre: allow=%b, want 0100", allow);
        end
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            drive(1, 1);
            want = (k >= 1 && k <= 5) ? 4'b0100 : (k == 8 ? 4'b1000 : 4'b0000);
            vectors++;
            if (allow !== want || phase !== 2'(k == 8 ? 3 : 2) || allow !== exp_allow()
                || phase_done !== exp_done()) begin
                errors++;
                $display("FAIL int_green k%0d: allow=%b phase=%0d done=%b, want %b/%0d/%b",
                         k, allow, phase, phase_done, want, (k == 8 ? 3 : 2), exp_done());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_interrupt_clear();
        int dones;
        logic [3:0] want;
        dones = 0;
        do_reset();
        run_to(1, 0, 1);
        drive(0, 1);
        vectors++;
        if (phase_done !== 1'b0 || allow !== 4'b0) begin
            errors++;
            $display("FAIL int_clear_cut: done=%b allow=%b, want 0/0000", phase_done, allow);
        end
        @(negedge clk);
        drive(0, 0);
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            drive(1, 1);
            want = (k >= 1 && k <= 5) ? 4'b0010 : 4'b0000;
            if (phase_done) dones++;
            vectors++;
            if (allow !== want || phase !== 2'd1 || allow !== exp_allow() || phase_done !== exp_done()) begin
                errors++;
                $display("FAIL int_clear k%0d: allow=%b phase=%0d done=%b, want %b/1/%b",
                         k, allow, phase, phase_done, want, exp_done());
            end
            @(negedge clk);
        end
        vectors++;
        if (dones != 0) begin
            errors++;
            $display("FAIL int_clear_done: %0d pulses, want 0", dones);
        end
    endtask

    task automatic test_rotations();
        int dones, greens;
        logic prev_done;
        logic [3:0] prev_allow;
        dones = 0; greens = 0; prev_done = 0; prev_allow = 0;
        do_reset();
        for (int c = 0; c <= 56; c++) begin
            drive(1, 1);
            vectors++;
            if (allow !== exp_allow() || phase !== 2'(m_phase) || phase_done !== exp_done()
                || $countones(allow) > 1 || (prev_done && phase_done)) begin
                errors++;
                $display("FAIL rotation c%0d: allow=%b phase=%0d done=%b, want %b/%0d/%b",
                         c, allow, phase, phase_done, exp_allow(), m_phase, exp_done());
            end
            if (allow != 0 && prev_allow == 0) begin
                vectors++;
                if (phase !== 2'(greens % 4)) begin
                    errors++;
                    $display("FAIL rotation_seq: green #%0d phase=%0d, want %0d", greens, phase, greens % 4);
                end
                greens++;
            end
            if (phase_done) dones++;
            prev_done = phase_done; prev_allow = allow;
            @(negedge clk);
        end
        vectors++;
        if (dones != 8) begin
            errors++;
            $display("FAIL rotation_done: %0d pulses, want 8", dones);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [3:0] first;
        first = 0;
        do_reset();
        run_to(3, 0, C);
        drive(1, 1);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (allow !== 4'b0 || phase !== 2'd0 || phase_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: allow=%b phase=%0d done=%b, want 0000/0/0", allow, phase, phase_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 1);
            if (first == 0) first = allow;
            vectors++;
            if (allow !== exp_allow() || phase !== 2'(m_phase) || phase_done !== exp_done()) begin
                errors++;
                $display("FAIL rst_resume k%0d: allow=%b phase=%0d, want %b/%0d",
                         k, allow, phase, exp_allow(), m_phase);
            end
            @(negedge clk);
        end
        vectors++;
        if (first !== 4'b0001) begin
            errors++;
            $display("FAIL rst_first: first allow=%b, want 0001", first);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) != 0));
            vectors++;
            if (allow !== exp_allow() || phase !== 2'(m_phase) || phase_done !== exp_done()) begin
                errors++;
                $display("FAIL random c%0d: allow=%b phase=%0d done=%b, want %b/%0d/%b",
                         c, allow, phase, phase_done, exp_allow(), m_phase, exp_done());
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b1; op_en = 1'b0; cnt_en = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_startup();
        test_freeze();
        test_interrupt_green();
        test_interrupt_clear();
        test_rotations();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
